// File: rtl/motor_pwm_decoder.sv
// Receive-side PWM decoder: recovers a signed per-side command from the fwd/rev
// drive pins by counting high cycles over each free-running 2**FRAME_BITS window.
module motor_pwm_decoder #(
  parameter int unsigned FRAME_BITS  = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fwd_lft,
  input  logic              rev_lft,
  input  logic              fwd_rht,
  input  logic              rev_rht,
  output logic [FRAME_BITS:0] lft_meas,
  output logic [FRAME_BITS:0] rht_meas,
  output logic              meas_vld,
  output logic              brk_lft,
  output logic              brk_rht,
  output logic              err_lft,
  output logic              err_rht
);

  localparam int unsigned CNT_W = FRAME_BITS + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(1) << FRAME_BITS;
  localparam logic [CNT_W-1:0] MAXP = FULL - CNT_W'(1);

  typedef enum logic {WARM, RUN} state_t;

  state_t                state;
  logic [FRAME_BITS-1:0] win_cnt;
  logic [3:0]            sync_q [SYNC_STAGES];
  logic [3:0]            s;
  logic                  win_end;

  logic [CNT_W-1:0] f_cnt [2];
  logic [CNT_W-1:0] r_cnt [2];
  logic [CNT_W-1:0] b_cnt [2];
  logic [CNT_W-1:0] f_tot [2];
  logic [CNT_W-1:0] r_tot [2];
  logic [CNT_W-1:0] b_tot [2];
  logic [CNT_W-1:0] meas_q   [2];
  logic [CNT_W-1:0] meas_nxt [2];
  logic [1:0]       brk_q;
  logic [1:0]       brk_nxt;
  logic [1:0]       err_q;
  logic [1:0]       err_nxt;

  // Bit order {rev_rht, fwd_rht, rev_lft, fwd_lft}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= {rev_rht, fwd_rht, rev_lft, fwd_lft};
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign win_end = (win_cnt == '1);

  // Priority classification of one side's completed window
  function automatic void classify(
    input  logic [CNT_W-1:0] f,
    input  logic [CNT_W-1:0] r,
    input  logic [CNT_W-1:0] b,
    input  logic [CNT_W-1:0] m_old,
    input  logic             brk_old,
    output logic [CNT_W-1:0] m,
    output logic             brk,
    output logic             err
  );
    m   = m_old;
    brk = brk_old;
    err = 1'b0;
    if (b == FULL) begin
      m   = '0;
      brk = 1'b1;
    end else if (f == '0 && r == '0) begin
      m   = '0;
      brk = 1'b0;
    end else if (r == '0) begin
      m   = (f == FULL) ? MAXP : f;
      brk = 1'b0;
    end else if (f == '0) begin
      m   = ~r + CNT_W'(1);
      brk = 1'b0;
    end else begin
      err = 1'b1;
    end
  endfunction

  // Totals include the current sample so the window-end cycle is counted
  always_comb begin
    f_tot[0] = f_cnt[0] + CNT_W'(s[0]);
    r_tot[0] = r_cnt[0] + CNT_W'(s[1]);
    b_tot[0] = b_cnt[0] + CNT_W'(s[0] & s[1]);
    f_tot[1] = f_cnt[1] + CNT_W'(s[2]);
    r_tot[1] = r_cnt[1] + CNT_W'(s[3]);
    b_tot[1] = b_cnt[1] + CNT_W'(s[2] & s[3]);
    meas_nxt[0] = '0;
    meas_nxt[1] = '0;
    brk_nxt     = '0;
    err_nxt     = '0;
    classify(f_tot[0], r_tot[0], b_tot[0], meas_q[0], brk_q[0],
             meas_nxt[0], brk_nxt[0], err_nxt[0]);
    classify(f_tot[1], r_tot[1], b_tot[1], meas_q[1], brk_q[1],
             meas_nxt[1], brk_nxt[1], err_nxt[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WARM;
      win_cnt  <= '0;
      meas_vld <= 1'b0;
      brk_q    <= '0;
      err_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        f_cnt[i]  <= '0;
        r_cnt[i]  <= '0;
        b_cnt[i]  <= '0;
        meas_q[i] <= '0;
      end
    end else begin
      win_cnt  <= win_cnt + FRAME_BITS'(1);
      meas_vld <= 1'b0;
      err_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        f_cnt[i] <= win_end ? '0 : f_tot[i];
        r_cnt[i] <= win_end ? '0 : r_tot[i];
        b_cnt[i] <= win_end ? '0 : b_tot[i];
      end
      if (win_end) begin
        if (state == WARM) begin
          // First window holds synchronizer fill; discard it
          state <= RUN;
        end else begin
          meas_vld  <= 1'b1;
          meas_q[0] <= meas_nxt[0];
          meas_q[1] <= meas_nxt[1];
          brk_q     <= brk_nxt;
          err_q     <= err_nxt;
        end
      end
    end
  end

  assign lft_meas = meas_q[0];
  assign rht_meas = meas_q[1];
  assign brk_lft  = brk_q[0];
  assign brk_rht  = brk_q[1];
  assign err_lft  = err_q[0];
  assign err_rht  = err_q[1];

endmodule
